// File: rtl/adc32_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master drives operands; the slave (the adder) returns the registered sum.
interface adc32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             C0;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             Co;
    logic             out_valid;

    modport master (
        output a, b, C0, in_valid,
        input  s, Co, out_valid
    );

    modport slave (
        input  a, b, C0, in_valid,
        output s, Co, out_valid
    );
endinterface

// File: rtl/adc32.sv
// Registered add-with-carry: {Co, s} = a + b + C0, one cycle latency.
// Two-level carry lookahead: 4-bit groups produce group P/G, and a second
// level forms every group carry-in directly from C0 and the lower groups'
// P/G, so no carry ripples across a group boundary.
module adc32 #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    adc32_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;
    logic             prod;
    logic             term;

    assign p   = bus.a ^ bus.b;
    assign g   = bus.a & bus.b;
    assign sum = p ^ c;

    // Group propagate / generate for each 4-bit slice.
    always_comb begin
        gp = '0;
        gg = '0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
    end

    // Second-level lookahead: each group carry-in as a flat sum of products
    // over C0 and all lower groups, rather than chained from its neighbour.
    always_comb begin
        gc    = '0;
        gc[0] = bus.C0;
        prod  = 1'b0;
        term  = 1'b0;
        for (int j = 1; j <= NG; j++) begin
            term = 1'b0;
            for (int k = 0; k < j; k++) begin
                prod = gg[k];
                for (int m = k + 1; m < j; m++) begin
                    prod = prod & gp[m];
                end
                term = term | prod;
            end
            prod = bus.C0;
            for (int m = 0; m < j; m++) begin
                prod = prod & gp[m];
            end
            gc[j] = term | prod;
        end
    end

    // In-group lookahead: bit carries from the group carry-in and local p/g.
    always_comb begin
        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    // Output registers load every edge; out_valid just tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s         <= '0;
            bus.Co        <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.s         <= sum;
            bus.Co        <= gc[NG];
            bus.out_valid <= bus.in_valid;
        end
    end
endmodule

// File: tb/tb_adc32.sv
// Self-checking bench for adc32: directed corner vectors, back-to-back
// pipelining, async reset and a long randomized run against a 33-bit
// arithmetic reference.
module tb_adc32;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    adc32_if #(.WIDTH(32)) bus ();

    adc32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {out_valid, Co, s} against the expected triple.
    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%b co=%b s=%h, expected v=%b co=%b s=%h",
                     tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [33:0] ref_sum(input logic [31:0] ra, input logic [31:0] rb,
                                             input logic rc, input logic rv);
        logic [32:0] full;
        full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
        return {rv, full};
    endfunction

    function automatic logic [33:0] observed();
        return {bus.out_valid, bus.Co, bus.s};
    endfunction

    // Called at a falling edge: drive operands, check one edge later, return to a falling edge.
    task automatic step(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic tv);
        bus.a        = ta;
        bus.b        = tb;
        bus.C0       = tc;
        bus.in_valid = tv;
        @(posedge clk);
        #1;
        check(tag, observed(), ref_sum(ta, tb, tc, tv));
        @(negedge clk);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'h0000_0001;
        bus.C0       = 1'b1;
        bus.in_valid = 1'b1;

        #1;
        check("reset_initial", observed(), 34'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", observed(), 34'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.C0 = 1'b0;

        step("prop_aa_55",   32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1);
        step("prop_aa_56",   32'hAAAA_AAAA, 32'h5555_5556, 1'b0, 1'b1);
        step("prop_aa_00",   32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 1'b1);
        step("ones_plus_0",  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        step("ones_plus_1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        step("ones_plus_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step("cin_ones",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        step("cin_zero",     32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        step("cin_7f",       32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        step("zero_zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);

        // Back-to-back operations with in_valid toggling.
        step("pipe_0", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
        step("pipe_1", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        step("pipe_2", 32'h0F0F_0F0F, 32'h00F0_F0F1, 1'b0, 1'b0);
        step("pipe_3", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b1);
        step("pipe_4", 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 1'b0);

        // Asynchronous reset asserted between edges clears outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", observed(), 34'd0);
        @(posedge clk);
        #1;
        check("async_reset_hold", observed(), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_first", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                step("rand_pre_reset", $urandom, $urandom, 1'b1, 1'b1);
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_async_reset", observed(), 34'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            step("random", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
